// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-enable sequencer.
// Holds the FSM state encoding and the shift-counter width helper.
// No ports; imported by shift_ena_seq and pattern_det.

package shift_seq_pkg;

  // Sequencer phases. BOOT and SHIFT both drive shift_ena, but only BOOT
  // returns straight to SEARCH; SHIFT continues into the count/ack handshake.
  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    SEARCH   = 3'd1,
    SHIFT    = 3'd2,
    COUNT    = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  // Width needed to hold the values 0..cycles inclusive. The counter is
  // loaded with the full cycle count, so the +1 matters when cycles is a
  // power of two. Clamped to 1 so the result is never zero.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/shift_ena_seq_pattern_det.sv
// Serial start-pattern detector: a sliding window over the incoming bit
// stream compared against a fixed pattern (MSB received first).
// Ports: clk, reset (async, active-high), clr (zero the history),
//        en (shift data into the history and allow a match), data (serial
//        input bit), match (combinational: {history, data} == PATTERN while en).

module pattern_det
  import shift_seq_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic data,
  output logic match
);

  // Only PATTERN_W-1 past bits are stored; the current input bit completes
  // the window, so a match is flagged in the same cycle the last bit arrives.
  logic [PATTERN_W-2:0] r_hist;
  logic [PATTERN_W-1:0] w_window;

  assign w_window = {r_hist, data};
  assign match    = en && (w_window == PATTERN);

  // clr wins over en so that re-entering the search always starts from an
  // empty history, even when the caller also holds en that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else if (clr) begin
      r_hist <= '0;
    end else if (en) begin
      r_hist <= w_window[PATTERN_W-2:0];
    end
  end

endmodule

// File: rtl/shift_ena_seq.sv
// Shift-enable sequencer: raises shift_ena for SHIFT_CYCLES cycles after
// reset release (optional boot load) and after every detected start pattern,
// then runs a count / done / acknowledge handshake after pattern shifts.
// Ports: clk, reset (async, active-high), data (serial stream),
//        done_counting (datapath counter finished), ack (consumer ack of done),
//        shift_ena / counting / done (Moore, one-hot or all zero),
//        shift_left (shift cycles remaining incl. current, 0 outside shifts).

module shift_ena_seq
  import shift_seq_pkg::*;
#(
  parameter int                   PATTERN_W    = 4,
  parameter logic [PATTERN_W-1:0] PATTERN      = 4'b1101,
  parameter int                   SHIFT_CYCLES = 4,
  parameter bit                   BOOT_SHIFT   = 1'b1,
  localparam int                  CW           = cnt_width(SHIFT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data,
  input  logic          done_counting,
  input  logic          ack,
  output logic          shift_ena,
  output logic          counting,
  output logic          done,
  output logic [CW-1:0] shift_left
);

  localparam logic [CW-1:0] CNT_LOAD    = CW'(SHIFT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam state_t        RESET_STATE = BOOT_SHIFT ? BOOT : SEARCH;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_in_shift;
  logic          w_cnt_last;
  logic          w_match;
  logic          w_search_en;
  logic          w_search_clr;

  assign w_in_shift = (r_state == BOOT) || (r_state == SHIFT);
  assign w_cnt_last = (r_cnt == CNT_ONE);

  // History only advances while searching, and is wiped on every entry
  // into SEARCH so each pattern must be received afresh.
  assign w_search_en  = (r_state == SEARCH);
  assign w_search_clr = (w_state_nxt == SEARCH) && (r_state != SEARCH);

  pattern_det #(
    .PATTERN_W (PATTERN_W),
    .PATTERN   (PATTERN)
  ) u_pattern_det (
    .clk   (clk),
    .reset (reset),
    .clr   (w_search_clr),
    .en    (w_search_en),
    .data  (data),
    .match (w_match)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Each input is looked at only in the state that
  // consumes it, so a done_counting or ack that is already high when the
  // FSM arrives is honoured one edge later, never on the arrival edge.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT: begin
        if (w_cnt_last) begin
          w_state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (w_match) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cnt_last) begin
          w_state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (done_counting) begin
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          w_state_nxt = SEARCH;
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
  end

  // Shift counter. Outside the shift phases it rests at the full load value,
  // which gives the "load on entry" behaviour for free: the first cycle of
  // BOOT or SHIFT always starts from SHIFT_CYCLES.
  always_comb begin
    w_cnt_nxt = CNT_LOAD;
    if (w_in_shift && !w_cnt_last) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= CNT_LOAD;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    shift_ena  = 1'b0;
    counting   = 1'b0;
    done       = 1'b0;
    shift_left = '0;
    if (w_in_shift) begin
      shift_ena  = 1'b1;
      shift_left = r_cnt;
    end
    if (r_state == COUNT) begin
      counting = 1'b1;
    end
    if (r_state == WAIT_ACK) begin
      done = 1'b1;
    end
  end

endmodule
